perm_rf_engine: RTL and testbench
=================================

Name: perm_rf_engine

Overview:
Parametrised permutation register file: DEPTH entries of WIDTH bits each, initialised to the identity permutation (r[i] = i).
Supports four operations on entries:
- single-cycle swap and direct write;
- multi-cycle range reverse and range rotate-left, executed as a sequence of pairwise swaps by an internal FSM.
Sits beside the datapath as a permutation/lookup table, with two combinational read ports and a valid/ready command interface.

Parameters:
DEPTH, 8, number of entries (>= 2)
WIDTH, 4, bits per entry (must be >= $clog2(DEPTH); identity values must fit)
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on posedge
init  in  1  synchronous active-high reset; loads identity permutation
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command (high only in IDLE)
cmd_op  in  2  operation: SWAP=0, REVERSE=1, ROTL=2, WRITE=3
cmd_a  in  AW  first address (WRITE target)
cmd_b  in  AW  second address (ignored for WRITE)
cmd_wdata  in  WIDTH  data for WRITE
done  out  1  one-cycle pulse: command completed
err  out  1  one-cycle pulse, coincident with done: command rejected
rd_addr0, rd_addr1  in  AW  read addresses
rd_data0, rd_data1  out  WIDTH  combinational r[rd_addrN]; 0 if rd_addrN >= DEPTH
r  out  WIDTH x DEPTH  full register array snapshot

Behaviour:
- init, sampled at posedge (synchronous):
  - r[i] <= i, truncated to WIDTH;
  - state <= IDLE; done <= 0; err <= 0;
  - overrides everything, including a command in progress; an aborted command never produces done.
- cmd_ready = (state == IDLE), combinational. A command is accepted at a posedge where cmd_valid && cmd_ready && !init.
- lo = min(cmd_a, cmd_b), hi = max(cmd_a, cmd_b), latched at acceptance.
- Range check: if cmd_a >= DEPTH, or (op != WRITE and cmd_b >= DEPTH):
  - no array change;
  - done and err pulse the next cycle;
  - stays IDLE.
- SWAP:
  - at the accepting edge, r[a] <= old r[b] and r[b] <= old r[a];
  - a == b gives no change;
  - done pulses in the following cycle; stays IDLE, so back-to-back commands are allowed.
- WRITE:
  - at the accepting edge, r[a] <= cmd_wdata;
  - done next cycle; stays IDLE.
- REVERSE:
  - if lo == hi: no change, done next cycle.
  - Otherwise go to RUN_REV. Each edge in RUN_REV swaps r[lo] and r[hi], then lo++ and hi--.
  - When the updated lo >= hi: go to IDLE and done <= 1 on that same edge.
  - Step count = floor((hi-lo+1)/2); cmd_ready is low for exactly that many cycles.
- ROTL over [lo..hi]:
  - result: r[lo] moves to r[hi]; r[lo+1..hi] shift down by one.
  - If lo == hi: no-op, done next cycle.
  - Otherwise go to RUN_ROT with p = lo. Each edge swaps r[p] and r[p+1], then p++. At the edge where p == hi-1 performs its swap, go to IDLE and done <= 1.
  - Takes hi-lo cycles.
- cmd_valid is ignored while busy; the command is not latched, and the requester must hold it until cmd_ready.
- done and err are registered; they are high for exactly one cycle after the completing edge and low otherwise.
- The r output and read ports reflect the registered array, so updates are visible in the cycle after the write edge.
- No two writes to the same entry ever occur on one edge. Required even for SWAP with a == b, which must be handled explicitly as no change.

Decomposition:
- Package perm_rf_pkg:
  - op_e enum (SWAP, REVERSE, ROTL, WRITE);
  - state_e enum (IDLE, RUN_REV, RUN_ROT);
  - op width constant.
- Single module; no sub-module is needed.
- Range-step logic (lo/hi/p counters) stays inline with the FSM.
- The two read ports are a generate loop in the same file.

Test Plan:
1. DEPTH=8, WIDTH=4, assert init 1 cycle -> r = {0,1,2,3,4,5,6,7}, cmd_ready=1, done=0, err=0.
2. SWAP a=2 b=5 -> next cycle r[2]=5, r[5]=2, done=1 for 1 cycle. Immediate second SWAP 2,5 restores identity. SWAP a=3 b=3 -> no change, done pulses.
3. REVERSE a=6 b=1 from identity -> cmd_ready low 3 cycles, then r = {0,6,5,4,3,2,1,7} with done pulse; cmd_valid held during busy is accepted only after ready returns.
4. ROTL a=0 b=3 from identity -> 3 busy cycles, r = {1,2,3,0,4,5,6,7}, done. ROTL a=4 b=4 -> no-op, done next cycle.
5. WRITE a=7 wdata=0xA -> r[7]=0xA, rd_addr0=7 gives rd_data0=0xA. Then REVERSE 0..7 with init asserted on the 2nd busy cycle -> r = identity, no done, cmd_ready=1 after the reset edge.
6. DEPTH=6 instance, SWAP a=6 b=1 -> done=1 and err=1 for 1 cycle, array unchanged; rd_addr1=7 gives rd_data1=0.

Source files
------------

// File: rtl/perm_rf_pkg.sv
// Shared types for the permutation register file: command opcodes and engine states.
package perm_rf_pkg;

  localparam int unsigned OpW = 2;

  typedef enum logic [OpW-1:0] {
    OpSwap    = 2'd0,
    OpReverse = 2'd1,
    OpRotl    = 2'd2,
    OpWrite   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRunRev,
    StRunRot
  } state_e;

endpackage

// File: rtl/perm_rf_engine_if.sv
// Command, completion and read-port bundle for perm_rf_engine.
interface perm_rf_engine_if
  import perm_rf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                         cmd_valid;
  logic                         cmd_ready;
  op_e                          cmd_op;
  logic [AW-1:0]                cmd_a;
  logic [AW-1:0]                cmd_b;
  logic [WIDTH-1:0]             cmd_wdata;
  logic                         done;
  logic                         err;
  logic [AW-1:0]                rd_addr0;
  logic [AW-1:0]                rd_addr1;
  logic [WIDTH-1:0]             rd_data0;
  logic [WIDTH-1:0]             rd_data1;
  logic [DEPTH-1:0][WIDTH-1:0]  r;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_wdata, rd_addr0, rd_addr1,
    input  cmd_ready, done, err, rd_data0, rd_data1, r
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_wdata, rd_addr0, rd_addr1,
    output cmd_ready, done, err, rd_data0, rd_data1, r
  );

endinterface

// File: rtl/perm_rf_engine.sv
// Permutation register file: identity on init, single-cycle swap/write, and
// multi-cycle range reverse / rotate-left built from pairwise swaps.
module perm_rf_engine
  import perm_rf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input logic             clk,
  input logic             init,
  perm_rf_engine_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  state_e                      state_q;
  logic [DEPTH-1:0][WIDTH-1:0] r_q;
  logic [AW-1:0]               lo_q, hi_q;
  logic                        done_q, err_q;

  logic [AW-1:0] cmd_lo, cmd_hi, lo_nx, hi_nx;
  logic          cmd_bad;

  always_comb begin
    cmd_lo  = (bus.cmd_a < bus.cmd_b) ? bus.cmd_a : bus.cmd_b;
    cmd_hi  = (bus.cmd_a < bus.cmd_b) ? bus.cmd_b : bus.cmd_a;
    cmd_bad = (32'(bus.cmd_a) >= DEPTH) ||
              ((bus.cmd_op != OpWrite) && (32'(bus.cmd_b) >= DEPTH));
    // No wrap: in the run states lo_q < hi_q <= DEPTH-1.
    lo_nx   = lo_q + AW'(1);
    hi_nx   = hi_q - AW'(1);
  end

  always_ff @(posedge clk) begin
    if (init) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= WIDTH'(i);
      state_q <= StIdle;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            if (cmd_bad) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              unique case (bus.cmd_op)
                OpSwap: begin
                  // a == b must not issue two writes to one entry.
                  if (bus.cmd_a != bus.cmd_b) begin
                    r_q[bus.cmd_a] <= r_q[bus.cmd_b];
                    r_q[bus.cmd_b] <= r_q[bus.cmd_a];
                  end
                  done_q <= 1'b1;
                end
                OpWrite: begin
                  r_q[bus.cmd_a] <= bus.cmd_wdata;
                  done_q         <= 1'b1;
                end
                OpReverse, OpRotl: begin
                  if (cmd_lo == cmd_hi) begin
                    done_q <= 1'b1;
                  end else begin
                    lo_q    <= cmd_lo;
                    hi_q    <= cmd_hi;
                    state_q <= (bus.cmd_op == OpReverse) ? StRunRev : StRunRot;
                  end
                end
                default: done_q <= 1'b1;
              endcase
            end
          end
        end
        StRunRev: begin
          r_q[lo_q] <= r_q[hi_q];
          r_q[hi_q] <= r_q[lo_q];
          lo_q      <= lo_nx;
          hi_q      <= hi_nx;
          if (lo_nx >= hi_nx) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        StRunRot: begin
          // Bubble the low entry up one slot per cycle; lo_q is the moving pointer.
          r_q[lo_q]  <= r_q[lo_nx];
          r_q[lo_nx] <= r_q[lo_q];
          lo_q       <= lo_nx;
          if (lo_q == hi_nx) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.r         = r_q;

  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  assign rd_addr[0] = bus.rd_addr0;
  assign rd_addr[1] = bus.rd_addr1;

  for (genvar g = 0; g < 2; g++) begin : g_rd
    assign rd_data[g] = (32'(rd_addr[g]) < DEPTH) ? r_q[rd_addr[g]] : '0;
  end

  assign bus.rd_data0 = rd_data[0];
  assign bus.rd_data1 = rd_data[1];

endmodule

// File: tb/tb_perm_rf_engine.sv
// Self-checking bench for perm_rf_engine: directed scenarios plus random commands
// compared against an array-level model of the permutation table.
module tb_perm_rf_engine;
  import perm_rf_pkg::*;

  logic clk = 1'b0;
  logic init;
  always #5 clk = ~clk;

  perm_rf_engine_if #(.DEPTH(8), .WIDTH(4)) bus8 ();
  perm_rf_engine_if #(.DEPTH(6), .WIDTH(4)) bus6 ();

  perm_rf_engine #(.DEPTH(8), .WIDTH(4)) dut8 (.clk(clk), .init(init), .bus(bus8.slave));
  perm_rf_engine #(.DEPTH(6), .WIDTH(4)) dut6 (.clk(clk), .init(init), .bus(bus6.slave));

  int errs   = 0;
  int checks = 0;
  int m8[8];

  function automatic logic [31:0] pack8();
    logic [31:0] p;
    for (int i = 0; i < 8; i++) p[i*4 +: 4] = m8[i][3:0];
    return p;
  endfunction

  function automatic void model_identity();
    for (int i = 0; i < 8; i++) m8[i] = i;
  endfunction

  // Whole-array semantics of each command; busy is the expected cmd_ready-low count.
  function automatic void model8(input int op, input int a, input int b, input int wd,
                                 output bit e, output int busy);
    int old[8];
    int lo, hi;
    old  = m8;
    e    = 1'b0;
    busy = 0;
    if (a >= 8 || (op != 3 && b >= 8)) begin
      e = 1'b1;
      return;
    end
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    case (op)
      0: begin m8[a] = old[b]; m8[b] = old[a]; end
      1: begin
        for (int k = 0; k <= hi - lo; k++) m8[lo+k] = old[hi-k];
        busy = (hi - lo + 1) / 2;
      end
      2: begin
        for (int k = lo; k < hi; k++) m8[k] = old[k+1];
        m8[hi] = old[lo];
        busy = hi - lo;
      end
      default: m8[a] = wd & 15;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    step();
    init = 1'b0;
    model_identity();
  endtask

  // Issue one command on the DEPTH=8 instance and wait (bounded) for done.
  task automatic send8(input int op, input int a, input int b, input int wd,
                       output int busy, output bit d, output bit e);
    bus8.cmd_valid = 1'b1;
    bus8.cmd_op    = op_e'(op[1:0]);
    bus8.cmd_a     = a[2:0];
    bus8.cmd_b     = b[2:0];
    bus8.cmd_wdata = wd[3:0];
    step();
    bus8.cmd_valid = 1'b0;
    busy = 0;
    for (int n = 0; n < 64 && !bus8.done; n++) begin
      if (!bus8.cmd_ready) busy++;
      step();
    end
    d = bus8.done;
    e = bus8.err;
  endtask

  task automatic test_reset();
    bus8.cmd_valid = 1'b0; bus8.cmd_op = OpSwap; bus8.cmd_a = '0; bus8.cmd_b = '0;
    bus8.cmd_wdata = '0; bus8.rd_addr0 = '0; bus8.rd_addr1 = '0;
    bus6.cmd_valid = 1'b0; bus6.cmd_op = OpSwap; bus6.cmd_a = '0; bus6.cmd_b = '0;
    bus6.cmd_wdata = '0; bus6.rd_addr0 = '0; bus6.rd_addr1 = '0;
    do_init();
    checks++;
    if (bus8.r !== 32'h7654_3210) begin
      errs++; $display("FAIL reset_r8 got=%h want=%h", bus8.r, 32'h7654_3210);
    end
    checks++;
    if (bus6.r !== 24'h54_3210) begin
      errs++; $display("FAIL reset_r6 got=%h want=%h", bus6.r, 24'h54_3210);
    end
    checks++;
    if ({bus8.cmd_ready, bus8.done, bus8.err} !== 3'b100) begin
      errs++; $display("FAIL reset_flags got=%b want=100",
                       {bus8.cmd_ready, bus8.done, bus8.err});
    end
  endtask

  task automatic test_swap();
    int busy; bit d, e, me; int mb;
    int ops[3][2] = '{'{2, 5}, '{2, 5}, '{3, 3}};
    for (int t = 0; t < 3; t++) begin
      model8(0, ops[t][0], ops[t][1], 0, me, mb);
      send8(0, ops[t][0], ops[t][1], 0, busy, d, e);
      checks++;
      if ({d, e, busy} !== {1'b1, 1'b0, 32'd0}) begin
        errs++; $display("FAIL swap%0d_done got=%b%b busy=%0d want=10 busy=0", t, d, e, busy);
      end
      checks++;
      if (bus8.r !== pack8()) begin
        errs++; $display("FAIL swap%0d_r got=%h want=%h", t, bus8.r, pack8());
      end
    end
    step();
    checks++;
    if (bus8.done !== 1'b0) begin
      errs++; $display("FAIL swap_done_pulse got=%b want=0", bus8.done);
    end
  endtask

  task automatic test_reverse_held();
    int busy; bit me; int mb;
    model8(1, 6, 1, 0, me, mb);
    bus8.cmd_valid = 1'b1; bus8.cmd_op = OpReverse; bus8.cmd_a = 3'd6; bus8.cmd_b = 3'd1;
    step();
    // A second command is presented while busy and must wait for cmd_ready.
    bus8.cmd_op = OpSwap; bus8.cmd_a = 3'd0; bus8.cmd_b = 3'd7;
    busy = 0;
    for (int n = 0; n < 64 && !bus8.done; n++) begin
      if (!bus8.cmd_ready) busy++;
      step();
    end
    checks++;
    if (busy !== 3 || bus8.done !== 1'b1) begin
      errs++; $display("FAIL rev_busy got=%0d done=%b want=3 done=1", busy, bus8.done);
    end
    checks++;
    if (bus8.r !== 32'h7123_4560) begin
      errs++; $display("FAIL rev_r got=%h want=%h", bus8.r, 32'h7123_4560);
    end
    model8(0, 0, 7, 0, me, mb);
    step();
    bus8.cmd_valid = 1'b0;
    checks++;
    if (bus8.done !== 1'b1 || bus8.r !== pack8()) begin
      errs++; $display("FAIL held_swap got=%h done=%b want=%h done=1", bus8.r, bus8.done, pack8());
    end
    step();
    checks++;
    if (bus8.done !== 1'b0) begin
      errs++; $display("FAIL held_done_pulse got=%b want=0", bus8.done);
    end
  endtask

  task automatic test_rotl();
    int busy; bit d, e;
    do_init();
    send8(2, 0, 3, 0, busy, d, e);
    checks++;
    if (busy !== 3 || bus8.r !== 32'h7654_0321 || d !== 1'b1) begin
      errs++; $display("FAIL rotl03 got=%h busy=%0d want=%h busy=3", bus8.r, busy, 32'h7654_0321);
    end
    send8(2, 4, 4, 0, busy, d, e);
    checks++;
    if (busy !== 0 || bus8.r !== 32'h7654_0321 || d !== 1'b1 || e !== 1'b0) begin
      errs++; $display("FAIL rotl44 got=%h busy=%0d want=%h busy=0", bus8.r, busy, 32'h7654_0321);
    end
    do_init();
  endtask

  task automatic test_write_abort();
    int busy; bit d, e;
    send8(3, 7, 0, 10, busy, d, e);
    bus8.rd_addr0 = 3'd7;
    #1;
    checks++;
    if (bus8.rd_data0 !== 4'hA || d !== 1'b1) begin
      errs++; $display("FAIL write_rd got=%h want=a", bus8.rd_data0);
    end
    bus8.cmd_valid = 1'b1; bus8.cmd_op = OpReverse; bus8.cmd_a = 3'd0; bus8.cmd_b = 3'd7;
    step();
    bus8.cmd_valid = 1'b0;
    step();
    init = 1'b1;
    step();
    init = 1'b0;
    model_identity();
    checks++;
    if (bus8.r !== 32'h7654_3210 || bus8.cmd_ready !== 1'b1 || bus8.done !== 1'b0) begin
      errs++; $display("FAIL abort got=%h rdy=%b done=%b want=76543210 rdy=1 done=0",
                       bus8.r, bus8.cmd_ready, bus8.done);
    end
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if (bus8.done !== 1'b0) begin
        errs++; $display("FAIL abort_no_done cyc=%0d got=%b want=0", n, bus8.done);
      end
    end
  endtask

  task automatic test_range6();
    bus6.cmd_valid = 1'b1; bus6.cmd_op = OpSwap; bus6.cmd_a = 3'd6; bus6.cmd_b = 3'd1;
    step();
    bus6.cmd_valid = 1'b0;
    bus6.rd_addr0 = 3'd5; bus6.rd_addr1 = 3'd7;
    #1;
    checks++;
    if ({bus6.done, bus6.err} !== 2'b11 || bus6.r !== 24'h54_3210) begin
      errs++; $display("FAIL range6 got=%b%b r=%h want=11 r=543210", bus6.done, bus6.err, bus6.r);
    end
    checks++;
    if (bus6.rd_data0 !== 4'h5 || bus6.rd_data1 !== 4'h0) begin
      errs++; $display("FAIL rd6 got=%h,%h want=5,0", bus6.rd_data0, bus6.rd_data1);
    end
    // WRITE ignores an out-of-range cmd_b.
    bus6.cmd_valid = 1'b1; bus6.cmd_op = OpWrite; bus6.cmd_a = 3'd2; bus6.cmd_b = 3'd7;
    bus6.cmd_wdata = 4'hC;
    step();
    bus6.cmd_valid = 1'b0;
    checks++;
    if ({bus6.done, bus6.err} !== 2'b10 || bus6.r !== 24'h54_3C10 || bus6.cmd_ready !== 1'b1) begin
      errs++; $display("FAIL write6 got=%b%b r=%h want=10 r=543c10", bus6.done, bus6.err, bus6.r);
    end
    step();
    checks++;
    if ({bus6.done, bus6.err} !== 2'b00) begin
      errs++; $display("FAIL range6_pulse got=%b%b want=00", bus6.done, bus6.err);
    end
  endtask

  task automatic test_random();
    int busy, mb, op, a, b, wd, ra;
    bit d, e, me;
    for (int t = 0; t < 60; t++) begin
      op = int'($urandom_range(3, 0));
      a  = int'($urandom_range(7, 0));
      b  = int'($urandom_range(7, 0));
      wd = int'($urandom_range(15, 0));
      model8(op, a, b, wd, me, mb);
      send8(op, a, b, wd, busy, d, e);
      checks++;
      if (d !== 1'b1 || e !== me || busy !== mb || bus8.r !== pack8()) begin
        errs++; $display("FAIL rand%0d op=%0d a=%0d b=%0d got=%h busy=%0d err=%b want=%h busy=%0d err=%b",
                         t, op, a, b, bus8.r, busy, e, pack8(), mb, me);
      end
      ra = int'($urandom_range(7, 0));
      bus8.rd_addr1 = ra[2:0];
      #1;
      checks++;
      if (bus8.rd_data1 !== m8[ra][3:0]) begin
        errs++; $display("FAIL rand%0d_rd got=%h want=%h", t, bus8.rd_data1, m8[ra][3:0]);
      end
    end
  endtask

  initial begin
    init = 1'b0;
    step();
    test_reset();
    test_swap();
    test_reverse_held();
    test_rotl();
    test_write_abort();
    test_range6();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
